// File: rtl/srdl_reg_access_seq.sv
// srdl_reg_access_seq
//
// Register-access sequencer that sits between the host register bus and the
// array of generated srdlField registers. It takes one valid/ready request at
// a time and decodes the word address. It drives the shared acc/rd/wr/sw_wdata
// strobes to exactly one register, then captures that register's read data
// and returns a valid/ready response. Registers flagged in EXT_MASK are
// external: their strobes are held until ext_ack.
//
// Optional feature macro: SRDL_SEQ_TIMEOUT_EN
//   When defined, an external wait is abandoned after TIMEOUT+1 strobe cycles
//   without ext_ack, and an error response is returned.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   word index and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    read data (0 for writes/errors), decode/timeout error
//   acc                   one-hot register select
//   rd, wr                read / write strobes, qualified by acc
//   sw_wdata              write data to the fields
//   reg_rdata             flattened register values, slice i = [i*DW +: DW]
//   ext_ack               selected external register completed the access
module srdl_reg_access_seq #(
  parameter int                NREGS    = 16,
  parameter int                AW       = 4,
  parameter int                DW       = 32,
  parameter logic [NREGS-1:0]  EXT_MASK = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AW-1:0]       req_addr,
  input  logic [DW-1:0]       req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  output logic [NREGS-1:0]    acc,
  output logic                rd,
  output logic                wr,
  output logic [DW-1:0]       sw_wdata,
  input  logic [NREGS*DW-1:0] reg_rdata,
  input  logic                ext_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    EXT_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [NREGS-1:0]  acc_q, acc_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DW-1:0]     sw_wdata_q, sw_wdata_d;

  logic [NREGS-1:0]  addr_dec;
  logic              addr_ok;
  logic              addr_ext;
  logic [DW-1:0]     sel_rdata;

`ifdef SRDL_SEQ_TIMEOUT_EN
  localparam int           CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
  logic [CW-1:0]           cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Address decode of the incoming request; out-of-range addresses decode to
  // an all-zero select so no strobe can ever reach a register.
  always_comb begin
    addr_dec = '0;
    for (int i = 0; i < NREGS; i++) begin
      addr_dec[i] = (req_addr == AW'(i));
    end
  end

  assign addr_ok  = ({1'b0, req_addr} < (AW+1)'(NREGS));
  assign addr_ext = |(addr_dec & EXT_MASK);

  // Read-data mux keyed on the registered select, so the value captured is
  // the one seen during the strobe cycle (pre-side-effect for rclr/rset).
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (acc_q[i]) sel_rdata = sel_rdata | reg_rdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    acc_d       = acc_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    sw_wdata_d  = sw_wdata_q;
`ifdef SRDL_SEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          sw_wdata_d = req_wdata;
          if (!addr_ok) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            acc_d   = addr_dec;
            rd_d    = ~req_write;
            wr_d    = req_write;
            state_d = addr_ext ? EXT_WAIT : ACCESS;
`ifdef SRDL_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      ACCESS: begin
        state_d     = RESP;
        acc_d       = '0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rd_q ? sel_rdata : '0;
      end

      EXT_WAIT: begin
        // ext_ack takes priority over the timeout limit in the same cycle.
        if (ext_ack) begin
          state_d     = RESP;
          acc_d       = '0;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = rd_q ? sel_rdata : '0;
        end
`ifdef SRDL_SEQ_TIMEOUT_EN
        else if (cnt_q == TO_LIM) begin
          state_d     = RESP;
          acc_d       = '0;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered ready: high exactly in the cycles the FSM sits in IDLE.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      acc_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      sw_wdata_q  <= '0;
`ifdef SRDL_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      acc_q       <= acc_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      sw_wdata_q  <= sw_wdata_d;
`ifdef SRDL_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign acc       = acc_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign sw_wdata  = sw_wdata_q;

endmodule

// File: tb/tb_srdl_reg_access_seq.sv
// Testbench for srdl_reg_access_seq: 12 registers, register 5 external,
// TIMEOUT=4 (only meaningful when SRDL_SEQ_TIMEOUT_EN is defined).
module tb_srdl_reg_access_seq;

  localparam int               NREGS    = 12;
  localparam int               AW       = 4;
  localparam int               DW       = 32;
  localparam logic [NREGS-1:0] EXT_MASK = 12'h020;
  localparam int               TIMEOUT  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [AW-1:0]       req_addr;
  logic [DW-1:0]       req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic [NREGS-1:0]    acc;
  logic                rd;
  logic                wr;
  logic [DW-1:0]       sw_wdata;
  logic [NREGS*DW-1:0] reg_rdata;
  logic                ext_ack;

  srdl_reg_access_seq #(
    .NREGS(NREGS), .AW(AW), .DW(DW), .EXT_MASK(EXT_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .acc(acc), .rd(rd), .wr(wr), .sw_wdata(sw_wdata),
    .reg_rdata(reg_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    int               ack_dly;
    logic [NREGS-1:0] exp_acc;
    logic [DW-1:0]    exp_rdata;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  vec_t         vecs[11];
  rsp_t         sb_q[$];
  logic [DW-1:0] regval[NREGS];
  int           checks = 0;
  int           errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pop_and_check(input string nm);
    rsp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty actual=0 required=1", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_rdata"}, rsp_rdata, e.rdata);
      chk({nm, "_err"}, rsp_err, e.err);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int               t;
    int               n;
    int               exp_lat;
    int               exp_n;
    logic             is_ext;
    logic             held_ok;
    logic [NREGS-1:0] a0;
    logic             r0, w0;
    logic [DW-1:0]    d0;
    string            nm;
    nm      = $sformatf("v%0d", idx);
    is_ext  = ((v.exp_acc & EXT_MASK) != '0);
    exp_lat = v.exp_err ? 1 : (is_ext ? v.ack_dly + 2 : 2);
    exp_n   = v.exp_err ? 0 : (is_ext ? v.ack_dly + 1 : 1);

    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    t = 0;
    while (!req_ready && t < 20) begin
      tick();
      t++;
    end
    chk({nm, "_req_ready"}, req_ready, 1);
    sb_q.push_back('{v.exp_rdata, v.exp_err});
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;
    chk({nm, "_busy"}, req_ready, 0);

    a0 = acc; r0 = rd; w0 = wr; d0 = sw_wdata;
    n = 0; t = 1; held_ok = 1'b1;
    while (!rsp_valid && t < 300) begin
      if (acc != '0 || rd || wr) begin
        n++;
        if (acc !== a0 || rd !== r0 || wr !== w0 || sw_wdata !== d0) held_ok = 1'b0;
      end
      ext_ack = is_ext && (n == v.ack_dly + 1);
      tick();
      t++;
    end
    ext_ack = 1'b0;

    chk({nm, "_latency"}, t, exp_lat);
    chk({nm, "_strobe_cycles"}, n, exp_n);
    chk({nm, "_acc"}, a0, v.exp_acc);
    chk({nm, "_rd"}, r0, !v.exp_err && !v.wr);
    chk({nm, "_wr"}, w0, !v.exp_err && v.wr);
    if (!v.exp_err && v.wr) chk({nm, "_sw_wdata"}, d0, v.wdata);
    chk({nm, "_strobes_held"}, held_ok, 1);
    chk({nm, "_strobes_off"}, {acc != '0, rd, wr}, 0);
    pop_and_check(nm);

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({nm, "_rsp_drop"}, rsp_valid, 0);
    chk({nm, "_req_ready_back"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   rd_cnt;
    int   vcnt;
    int   n;
    int   t;
    logic stable;

    for (int i = 0; i < NREGS; i++) regval[i] = 32'h1000_0000 | i;
    regval[3] = 32'hA5A5_0001;
    regval[5] = 32'h0000_DEAD;
    for (int i = 0; i < NREGS; i++) reg_rdata[i*DW +: DW] = regval[i];

    vecs[0]  = '{1'b0, 4'd3,  32'h0,         0, 12'h008, 32'hA5A5_0001, 1'b0};
    vecs[1]  = '{1'b1, 4'd0,  32'h0000_1234, 0, 12'h001, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 4'd15, 32'h0,         0, 12'h000, 32'h0,         1'b1};
    vecs[3]  = '{1'b0, 4'd5,  32'h0,         3, 12'h020, 32'h0000_DEAD, 1'b0};
    vecs[4]  = '{1'b0, 4'd11, 32'h0,         0, 12'h800, 32'h1000_000B, 1'b0};
    vecs[5]  = '{1'b1, 4'd5,  32'hCAFE_F00D, 0, 12'h020, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 4'd12, 32'h0,         0, 12'h000, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 4'd13, 32'h5555_AAAA, 0, 12'h000, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 4'd0,  32'h0,         0, 12'h001, 32'h1000_0000, 1'b0};
    vecs[9]  = '{1'b0, 4'd5,  32'h0,         4, 12'h020, 32'h0000_DEAD, 1'b0};
    vecs[10] = '{1'b1, 4'd11, 32'hFFFF_FFFF, 0, 12'h800, 32'h0,         1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; ext_ack = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {acc != '0, rd, wr, rsp_err}, 0);
    chk("rst_data", {rsp_rdata, sw_wdata}, 0);
    rst = 1'b0;
    tick();
    chk("rst_release_ready", req_ready, 1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Backpressure: response held for many cycles, single rd pulse.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3; req_wdata = '0;
    sb_q.push_back('{32'hA5A5_0001, 1'b0});
    tick();
    rd_cnt = 0; vcnt = 0; stable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (rd) rd_cnt++;
      if (rsp_valid) begin
        if (vcnt == 0) pop_and_check("bp");
        vcnt++;
        if (rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
      end
      tick();
    end
    chk("bp_rd_pulses", rd_cnt, 1);
    chk("bp_valid_cycles", vcnt, 13);
    chk("bp_stable", stable, 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release", rsp_valid, 0);

`ifdef SRDL_SEQ_TIMEOUT_EN
    // External access with no ack: TIMEOUT+1 strobe cycles then error.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    tick();
    req_valid = 1'b0;
    n = 0; t = 1;
    while (!rsp_valid && t < 50) begin
      if (acc != '0) n++;
      tick();
      t++;
    end
    chk("to_strobe_cycles", n, TIMEOUT + 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_strobes_off", {acc != '0, rd, wr}, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    // Reset in the middle of an external wait aborts the request.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5; req_wdata = 32'h7777_7777;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstmid_acc", acc, 12'h020);
    rst = 1'b1;
    tick();
    chk("rstmid_ctrl", {req_ready, rsp_valid, rsp_err, rd, wr}, 0);
    chk("rstmid_acc_clr", acc, 0);
    chk("rstmid_data", {rsp_rdata, sw_wdata}, 0);
    rst = 1'b0;
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("rstmid_ready", req_ready, 1);
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid || acc != '0) vcnt++;
      tick();
    end
    chk("rstmid_no_rsp", vcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srdl_reg_access_seq.md
# srdl_reg_access_seq

Register-access sequencer between the host register bus and the array of generated `srdlField` registers. It accepts one valid/ready bus request at a time and decodes the word address. It drives the shared `acc`/`rd`/`wr`/`sw_wdata` strobes to exactly one register, and captures that register's read data. It then returns a valid/ready response. External registers, flagged per index, are handshaked with an acknowledge and an optional timeout.

## Interface
Parameters:
- `NREGS`, default 16: number of register slots; must be ≥ 2.
- `AW`, default 4: width of the word address; must satisfy 2^AW ≥ NREGS.
- `DW`, default 32: data width.
- `EXT_MASK`, default 0: NREGS-bit mask; bit i set means register i is external and needs `ext_ack`.
- `TIMEOUT`, default 255: cycle limit for an external wait; must be ≥ 1. Used only with `SRDL_SEQ_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: bus request present.
- `req_ready`, output, 1: sequencer accepts a request.
- `req_write`, input, 1: 1 = write, 0 = read.
- `req_addr`, input, AW: word index.
- `req_wdata`, input, DW: write data.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: bus accepts the response.
- `rsp_rdata`, output, DW: read data; 0 for writes and errors.
- `rsp_err`, output, 1: decode error or timeout.
- `acc`, output, NREGS: one-hot register select.
- `rd`, output, 1: read strobe, qualified by `acc`.
- `wr`, output, 1: write strobe, qualified by `acc`.
- `sw_wdata`, output, DW: write data to the fields.
- `reg_rdata`, input, NREGS*DW: flattened register values; slice i is bits [i*DW +: DW].
- `ext_ack`, input, 1: the selected external register completed the access.

## Operation
- States are IDLE, ACCESS, EXT_WAIT and RESP. Every output is registered.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `req_write`, `req_addr` and `req_wdata`.
  - If the address is ≥ NREGS, go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No strobe is issued.
  - If `EXT_MASK[addr]` is set, go to EXT_WAIT.
  - Otherwise, go to ACCESS.
- ACCESS lasts exactly one cycle:
  - `acc[addr]`=1, and `rd`=~write, `wr`=write. `sw_wdata` holds the latched data.
  - For a read, `reg_rdata[addr]` is captured in this same cycle. This gives the pre-side-effect value, so an `rclr`/`rset` field returns its old contents.
  - Then go to RESP with `rsp_err`=0.
- EXT_WAIT:
  - `acc`, `rd`/`wr` and `sw_wdata` are held asserted until `ext_ack`=1.
  - On the ack cycle, capture the read data (reads only) and drop all strobes on the next edge. Go to RESP with `rsp_err`=0.
  - `ext_ack` seen in any other state is ignored.
- RESP:
  - `rsp_valid`=1 and `rsp_rdata`/`rsp_err` are held stable until `rsp_ready`=1. Then go to IDLE.
  - `req_ready`=0 in every state except IDLE.
- Side effects occur exactly once per request. `rd` or `wr` is never asserted for more than one cycle on an internal register, and never re-asserted while waiting on `rsp_ready`.
- `rsp_rdata` is 0 for all writes.

## Timing
- Reset values: state=IDLE, and `req_ready`, `rsp_valid`, `rsp_err`, `rsp_rdata`, `acc`, `rd`, `wr` and `sw_wdata` are all 0.
- `req_ready` rises on the first cycle after `rst` is deasserted.
- Internal access:
  - Request handshake at cycle N.
  - Strobes at N+1.
  - `rsp_valid` at N+2.
  - With `rsp_ready` held at 1, the next request is accepted at N+3. Best-case throughput is one access per 3 cycles.
- Decode error: handshake at N, `rsp_valid` at N+1. No strobes.
- External access: strobes start at N+1. If `ext_ack` arrives at cycle M, strobes are low and `rsp_valid` is 1 at M+1.
- An `ext_ack` arriving in the first strobe cycle is valid and gives the minimum external latency.
- Reset asserted in any state:
  - Next cycle: IDLE with all outputs at reset values.
  - The in-flight strobes and the pending response are discarded. No response is ever issued for the aborted request.

## Configuration
- `SRDL_SEQ_TIMEOUT_EN` defined:
  - A counter of $clog2(TIMEOUT+1) bits clears on entry to EXT_WAIT and increments each cycle without `ext_ack`.
  - When the counter equals TIMEOUT, that cycle is the last strobe cycle. On the next edge, strobes drop and the block goes to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - An `ext_ack` in the same cycle as the limit wins and gives a normal response.
- `SRDL_SEQ_TIMEOUT_EN` not defined: no counter; EXT_WAIT waits indefinitely for `ext_ack`.

## Test plan
- Internal read: `reg_rdata` slice 3 = 0xA5A5_0001, read of addr 3, `rsp_ready`=1.
  - Required: `acc`=0x0008 and `rd`=1 for exactly one cycle.
  - Required: `rsp_rdata`=0xA5A5_0001 and `rsp_err`=0, two cycles after the handshake.
- Internal write of 0x1234 to addr 0.
  - Required: `wr`=1, `acc`=0x0001, `sw_wdata`=0x1234 for one cycle.
  - Required: response has `rsp_rdata`=0 and `rsp_err`=0.
- Read of addr 15 with NREGS=12.
  - Required: no strobes, `rsp_err`=1, `rsp_rdata`=0, one cycle after the handshake.
- External read, EXT_MASK bit 5 set, `ext_ack` pulsed 3 cycles after the strobes start, slice 5 = 0xDEAD.
  - Required: strobes held for 4 cycles, then `rsp_rdata`=0xDEAD.
- Backpressure: `rsp_ready` held low for 10 cycles after an internal read.
  - Required: response held stable and `req_ready`=0 throughout.
  - Required: `rd` pulsed only once.
- With `SRDL_SEQ_TIMEOUT_EN` and TIMEOUT=4, external access with no ack.
  - Required: `rsp_err`=1.
  - Separately: `rst` pulsed mid-EXT_WAIT gives all outputs 0 the next cycle and no response issued.
